// File: rtl/imem_fetch_if.sv
// Fetch-side bundle between the fetch unit, the dual-port instruction memory and decode.
// master = fetch unit; slave = memory/decode environment.
interface imem_fetch_if;
    logic [13:0] addra;
    logic [63:0] douta;
    logic [13:0] addrb;
    logic [63:0] doutb;
    logic        redirect_valid;
    logic [13:0] redirect_addr;
    logic        halt;
    logic [1:0]  pop_count;
    logic        out0_valid;
    logic [63:0] out0_data;
    logic [13:0] out0_addr;
    logic        out1_valid;
    logic [63:0] out1_data;
    logic [13:0] out1_addr;
    logic [13:0] fetch_pc;

    modport master (
        output addra, addrb, out0_valid, out0_data, out0_addr,
               out1_valid, out1_data, out1_addr, fetch_pc,
        input  douta, doutb, redirect_valid, redirect_addr, halt, pop_count
    );

    modport slave (
        input  addra, addrb, out0_valid, out0_data, out0_addr,
               out1_valid, out1_data, out1_addr, fetch_pc,
        output douta, doutb, redirect_valid, redirect_addr, halt, pop_count
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Dual-port instruction fetch into an in-order queue with redirect, halt and pop-count drain.
// Define IMEM_FETCH_PERF_EN to add the perf_words / perf_stall counters.
module imem_fetch_unit #(
    parameter int          QDEPTH   = 8,
    parameter logic [13:0] RESET_PC = 14'd0
) (
    input  logic         clk,
    input  logic         rst,
    imem_fetch_if.master bus
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0]  perf_words,
    output logic [31:0]  perf_stall
`endif
);
    localparam int AW     = 14;
    localparam int DATA_W = 64;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_STALL, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;

    logic [DATA_W-1:0]  data_q [QDEPTH];
    logic [AW-1:0]      addr_q [QDEPTH];

    logic [CNT_W-1:0]   pop_clamp, pops_eff, free;
    logic [1:0]         pushes;
    logic               can_push;
    logic [AW-1:0]      pc_plus1;
    logic [PTR_W-1:0]   wr_ptr0, wr_ptr1, rd_ptr1;

    assign pc_plus1 = pc_q + AW'(1);
    // New words land directly behind the current contents; a slot popped this cycle may be reused.
    assign wr_ptr0  = head_q + count_q[PTR_W-1:0];
    assign wr_ptr1  = wr_ptr0 + PTR_W'(1);
    assign rd_ptr1  = head_q + PTR_W'(1);

    always_comb begin
        pop_clamp = (bus.pop_count == 2'd3) ? CNT_W'(2) : CNT_W'(bus.pop_count);
        pops_eff  = (pop_clamp > count_q) ? count_q : pop_clamp;
        free      = CNT_W'(QDEPTH) - count_q + pops_eff;
        can_push  = ((state_q == S_FETCH) || (state_q == S_STALL)) &&
                    !bus.halt && !bus.redirect_valid;
        pushes    = 2'd0;
        if (can_push) begin
            if (free >= CNT_W'(2))      pushes = 2'd2;
            else if (free == CNT_W'(1)) pushes = 2'd1;
        end

        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                if (bus.halt)                state_d = S_HALT;
                else if (free == '0)         state_d = S_STALL;
            end
            S_STALL: if (free != '0)         state_d = S_FETCH;
            S_HALT:  if (!bus.halt)          state_d = S_FETCH;
            default:                         state_d = S_BOOT;
        endcase

        head_d  = head_q + pops_eff[PTR_W-1:0];
        count_d = count_q - pops_eff + CNT_W'(pushes);
        pc_d    = pc_q + AW'(pushes);
        // Redirect wins over pop, push and halt; halt still gates fetch once in FETCH.
        if (bus.redirect_valid) begin
            head_d  = head_q;
            count_d = '0;
            pc_d    = bus.redirect_addr;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushes != 2'd0) begin
            data_q[wr_ptr0] <= bus.douta;
            addr_q[wr_ptr0] <= pc_q;
        end
        if (pushes == 2'd2) begin
            data_q[wr_ptr1] <= bus.doutb;
            addr_q[wr_ptr1] <= pc_plus1;
        end
    end

    assign bus.addra      = pc_q;
    assign bus.addrb      = pc_plus1;
    assign bus.fetch_pc   = pc_q;
    assign bus.out0_valid = (count_q != '0);
    assign bus.out1_valid = (count_q >= CNT_W'(2));
    assign bus.out0_data  = bus.out0_valid ? data_q[head_q]  : '0;
    assign bus.out0_addr  = bus.out0_valid ? addr_q[head_q]  : '0;
    assign bus.out1_data  = bus.out1_valid ? data_q[rd_ptr1] : '0;
    assign bus.out1_addr  = bus.out1_valid ? addr_q[rd_ptr1] : '0;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_words_q, perf_words_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_words_d = perf_words_q + 32'(pushes);
        perf_stall_d = perf_stall_q;
        if ((state_q == S_STALL) || (state_q == S_HALT))
            perf_stall_d = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_words_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_words_q <= perf_words_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_words = perf_words_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: memory returns mem[i]=i; a scoreboard of expected fetch
// addresses is refilled on reset/redirect and drained as words are consumed by pops.
module tb_imem_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_fetch_if bus();

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_words, perf_stall;
    logic [31:0] stall_snap;
`endif

    imem_fetch_unit #(.QDEPTH(8), .RESET_PC(14'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .perf_words (perf_words),
        .perf_stall (perf_stall)
`endif
    );

    assign bus.douta = 64'(bus.addra);
    assign bus.doutb = 64'(bus.addrb);

    int errors = 0;
    int checks = 0;
    logic [13:0] sbq[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_restart(input logic [13:0] start);
        sbq.delete();
        for (int i = 0; i < 64; i++) sbq.push_back(start + 14'(i));
    endtask

    task automatic sb_take(input logic [13:0] a, input logic [63:0] d, input string tag);
        logic [13:0] e;
        e = 'x;
        if (sbq.size() != 0) e = sbq.pop_front();
        check_eq({tag, "_addr"}, 64'(a), 64'(e));
        check_eq({tag, "_data"}, d, 64'(e));
    endtask

    // Drive one cycle's inputs, score the words being consumed, advance past the edge.
    task automatic cyc(input logic [1:0] p, input logic h, input logic rv, input logic [13:0] ra);
        int n;
        bus.pop_count      = p;
        bus.halt           = h;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        if (rv) sb_restart(ra);
        else begin
            n = (p == 2'd3) ? 2 : int'(p);
            if (n >= 1 && bus.out0_valid) sb_take(bus.out0_addr, bus.out0_data, "pop0");
            if (n == 2 && bus.out1_valid) sb_take(bus.out1_addr, bus.out1_data, "pop1");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.pop_count = 2'd0; bus.halt = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_addr = 14'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out0_valid", bus.out0_valid, 0);
        check_eq("rst_out1_valid", bus.out1_valid, 0);
        check_eq("rst_out0_data", bus.out0_data, 0);
        check_eq("rst_out0_addr", bus.out0_addr, 0);
        check_eq("rst_out1_data", bus.out1_data, 0);
        check_eq("rst_fetch_pc", bus.fetch_pc, 0);
        check_eq("rst_addra", bus.addra, 0);
        check_eq("rst_addrb", bus.addrb, 1);

        // Fill after reset: BOOT cycle, then two words per cycle up to 8.
        rst = 1'b0;
        sb_restart(14'd0);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("boot_no_push", bus.out0_valid, 0);
        check_eq("boot_pc", bus.fetch_pc, 0);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("fill_out0_valid", bus.out0_valid, 1);
        check_eq("fill_out0_addr", bus.out0_addr, 0);
        check_eq("fill_out0_data", bus.out0_data, 0);
        check_eq("fill_out1_addr", bus.out1_addr, 1);
        check_eq("fill_out1_data", bus.out1_data, 1);
        check_eq("fill_pc2", bus.fetch_pc, 2);
        repeat (3) cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("full_pc8", bus.fetch_pc, 8);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("stall_pc8", bus.fetch_pc, 8);
        check_eq("stall_out1_valid", bus.out1_valid, 1);
`ifdef IMEM_FETCH_PERF_EN
        check_eq("perf_words_fill", perf_words, 8);
`endif

        // Steady two-per-cycle drain with pop-through; pop_count=3 behaves as 2.
        cyc(2'd2, 1'b0, 1'b0, 14'd0);
        cyc(2'd3, 1'b0, 1'b0, 14'd0);
        cyc(2'd2, 1'b0, 1'b0, 14'd0);
        check_eq("steady_pc14", bus.fetch_pc, 14);
        check_eq("steady_head6", bus.out0_addr, 6);
        check_eq("steady_full", bus.out1_valid, 1);

        // Single-slot fetch: count 7 pushes port A only, then a pop of 1 from full.
`ifdef IMEM_FETCH_PERF_EN
        stall_snap = perf_stall;
`endif
        cyc(2'd1, 1'b1, 1'b0, 14'd0);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("c7_pc_held", bus.fetch_pc, 14);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("c7_pc_plus1", bus.fetch_pc, 15);
        check_eq("c7_head7", bus.out0_addr, 7);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("c8_stall_pc", bus.fetch_pc, 15);
        cyc(2'd1, 1'b0, 1'b0, 14'd0);
        check_eq("pop1_pc16", bus.fetch_pc, 16);
        check_eq("pop1_full", bus.out1_valid, 1);
`ifdef IMEM_FETCH_PERF_EN
        check_eq("perf_stall_c7", perf_stall - stall_snap, 2);
`endif

        // Redirect to 100 with count 5 and pop_count 2.
        cyc(2'd2, 1'b1, 1'b0, 14'd0);
        cyc(2'd1, 1'b1, 1'b0, 14'd0);
        cyc(2'd2, 1'b0, 1'b1, 14'd100);
        bus.redirect_valid = 1'b0;
        check_eq("redir_flush", bus.out0_valid, 0);
        check_eq("redir_addra", bus.addra, 100);
        check_eq("redir_addrb", bus.addrb, 101);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("redir_out0_addr", bus.out0_addr, 100);
        check_eq("redir_out1_addr", bus.out1_addr, 101);
        check_eq("redir_pc", bus.fetch_pc, 102);
        cyc(2'd2, 1'b0, 1'b0, 14'd0);

        // Address wrap at the top of the 14-bit space.
        cyc(2'd0, 1'b0, 1'b1, 14'd16383);
        check_eq("wrap_addra", bus.addra, 16383);
        check_eq("wrap_addrb", bus.addrb, 0);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("wrap_pc1", bus.fetch_pc, 1);
        check_eq("wrap_out0_addr", bus.out0_addr, 16383);
        check_eq("wrap_out1_addr", bus.out1_addr, 0);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("wrap_pc3", bus.fetch_pc, 3);

        // Halt with count 4 and pop 1 for 4 cycles: drains, pc frozen.
`ifdef IMEM_FETCH_PERF_EN
        stall_snap = perf_stall;
`endif
        repeat (4) cyc(2'd1, 1'b1, 1'b0, 14'd0);
        check_eq("halt_drained0", bus.out0_valid, 0);
        check_eq("halt_drained1", bus.out1_valid, 0);
        check_eq("halt_pc", bus.fetch_pc, 3);
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("unhalt_pc", bus.fetch_pc, 3);
`ifdef IMEM_FETCH_PERF_EN
        check_eq("perf_stall_halt", perf_stall - stall_snap, 4);
`endif
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("resume_pc", bus.fetch_pc, 5);
        check_eq("resume_out0_addr", bus.out0_addr, 3);
        cyc(2'd2, 1'b0, 1'b0, 14'd0);

        // Reset mid-operation discards queued words.
        rst = 1'b1;
        cyc(2'd0, 1'b0, 1'b0, 14'd0);
        check_eq("midrst_out0_valid", bus.out0_valid, 0);
        check_eq("midrst_pc", bus.fetch_pc, 0);
`ifdef IMEM_FETCH_PERF_EN
        check_eq("midrst_perf_words", perf_words, 0);
`endif
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
